// File: rtl/vga_frame_reader.sv
// Raster scan for a VGA display: reads a grey image from RAM and emits RGB with hsync/vsync aligned to the pixel data.
// Optional VGA_FRAME_BORDER_EN draws a white one-pixel frame around the image window.
module vga_frame_reader #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned IMG_W      = 256,
  parameter int unsigned IMG_H      = 256,
  parameter int unsigned IMG_X0     = 192,
  parameter int unsigned IMG_Y0     = 112,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] rd_data,
  output logic [31:0] rd_addr,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        active,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  typedef struct packed {
    logic vis;
    logic hs_n;
    logic vs_n;
    logic in_img;
    logic border;
    logic fs;
  } tag_t;

  localparam tag_t TAG_IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1, in_img: 1'b0, border: 1'b0, fs: 1'b0};

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [31:0]   h32;
  logic [31:0]   v32;
  tag_t          s0;
  tag_t          dly [0:RD_LATENCY];
  logic [7:0]    pix;
  logic          unused_rd_data;

  assign h32 = 32'(hcnt);
  assign v32 = 32'(vcnt);
  assign unused_rd_data = ^rd_data[31:8];

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h32 == H_TOTAL - 1) begin
      hcnt <= '0;
      vcnt <= (v32 == V_TOTAL - 1) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_comb begin
    s0        = TAG_IDLE;
    s0.vis    = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
    s0.hs_n   = !((h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC));
    s0.vs_n   = !((v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC));
    s0.in_img = s0.vis && (h32 >= IMG_X0) && (h32 < IMG_X0 + IMG_W)
                && (v32 >= IMG_Y0) && (v32 < IMG_Y0 + IMG_H);
    s0.fs     = (hcnt == '0) && (vcnt == '0);
`ifdef VGA_FRAME_BORDER_EN
    // Ring one pixel outside the window; corners belong to both edges.
    s0.border = s0.vis && (
      ((h32 == IMG_X0 - 1 || h32 == IMG_X0 + IMG_W) && (v32 + 1 >= IMG_Y0) && (v32 <= IMG_Y0 + IMG_H)) ||
      ((v32 == IMG_Y0 - 1 || v32 == IMG_Y0 + IMG_H) && (h32 + 1 >= IMG_X0) && (h32 <= IMG_X0 + IMG_W)));
`else
    s0.border = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr <= '0;
    end else if (enable && s0.in_img) begin
      rd_addr <= BASE_ADDR + (v32 - IMG_Y0) * IMG_W + (h32 - IMG_X0);
    end
  end

  // Sync/visibility tags travel alongside the RAM read so they meet rd_data.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      for (int i = 0; i <= RD_LATENCY; i++) dly[i] <= TAG_IDLE;
    end else begin
      dly[0] <= s0;
      for (int i = 1; i <= RD_LATENCY; i++) dly[i] <= dly[i-1];
    end
  end

  assign pix = dly[RD_LATENCY].in_img ? rd_data[7:0] :
               (dly[RD_LATENCY].border ? 8'hFF : 8'h00);

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= dly[RD_LATENCY].hs_n;
      vsync       <= dly[RD_LATENCY].vs_n;
      red         <= pix;
      green       <= pix;
      blue        <= pix;
      active      <= dly[RD_LATENCY].vis;
      frame_start <= dly[RD_LATENCY].fs;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a scaled-down raster; a positional model predicts every output cycle.
// Border expectations follow VGA_FRAME_BORDER_EN.
module tb_vga_frame_reader;

  localparam int HA = 64, HFP = 8, HSW = 16, HBP = 8;
  localparam int VA = 40, VFP = 3, VSW = 2, VBP = 5;
  localparam int W = 32, H = 16, X0 = 16, Y0 = 10;
  localparam logic [31:0] BASE = 32'h1000;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [27:0] IDLE_VEC = {1'b1, 1'b1, 24'h0, 1'b0, 1'b0};
`ifdef VGA_FRAME_BORDER_EN
  localparam logic [7:0] BORDER_PIX = 8'hFF;
`else
  localparam logic [7:0] BORDER_PIX = 8'h00;
`endif

  logic clk = 1'b0;
  logic reset, enable;
  logic [31:0] rd_data, rd_addr;
  logic hsync, vsync, active, frame_start;
  logic [7:0] red, green, blue;
  logic [7:0] key = 8'h00;
  logic [27:0] obs;

  always #5 clk = ~clk;

  vga_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .IMG_W(W), .IMG_H(H), .IMG_X0(X0), .IMG_Y0(Y0),
    .BASE_ADDR(BASE), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .rd_data(rd_data), .rd_addr(rd_addr),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .active(active), .frame_start(frame_start)
  );

  // Image RAM: one-cycle read, low byte derived from the address, upper bits noise.
  always @(posedge clk) rd_data <= {24'($urandom()), rd_addr[7:0] ^ key};

  assign obs = {hsync, vsync, red, green, blue, active, frame_start};

  typedef struct packed {
    logic [27:0] vec;
    int h;
    int v;
  } rec_t;

  int n_cmp = 0, n_bad = 0;
  int pos = 0, run = 0, s0_h = -1, s0_v = -1;
  rec_t hist [3];
  rec_t exp_out;
  logic [31:0] exp_addr = 32'h0;

  function automatic bit in_img(int h, int v);
    return h < HA && v < VA && h >= X0 && h < X0 + W && v >= Y0 && v < Y0 + H;
  endfunction

  function automatic logic [31:0] img_addr(int h, int v);
    return BASE + 32'((v - Y0) * W + (h - X0));
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r.vec = IDLE_VEC; r.h = -1; r.v = -1;
    return r;
  endfunction

  function automatic rec_t pixel(int h, int v);
    rec_t r;
    bit vis, hs, vs, bord;
    logic [31:0] a;
    logic [7:0] p;
    vis  = h < HA && v < VA;
    hs   = !(h >= HA + HFP && h < HA + HFP + HSW);
    vs   = !(v >= VA + VFP && v < VA + VFP + VSW);
    bord = vis && (((h == X0 - 1 || h == X0 + W) && v >= Y0 - 1 && v <= Y0 + H) ||
                   ((v == Y0 - 1 || v == Y0 + H) && h >= X0 - 1 && h <= X0 + W));
    a = img_addr(h, v);
    if (in_img(h, v)) p = a[7:0] ^ key;
    else if (bord)    p = BORDER_PIX;
    else              p = 8'h00;
    r.vec = {hs, vs, p, p, p, vis, (h == 0 && v == 0)};
    r.h = h; r.v = v;
    return r;
  endfunction

  // Drive one clock with the given inputs and advance the model; returns at the falling edge.
  task automatic tick(input logic r, input logic e);
    int h, v;
    bit live;
    rec_t cur;
    reset = r; enable = e;
    @(posedge clk);
    live = !r && e;
    h = pos % HT; v = pos / HT;
    cur = live ? pixel(h, v) : idle_rec();
    run = live ? run + 1 : 0;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = cur;
    exp_out = (run >= 3) ? hist[2] : idle_rec();
    if (r) exp_addr = 32'h0;
    else if (live && in_img(h, v)) exp_addr = img_addr(h, v);
    s0_h = live ? h : -1; s0_v = live ? v : -1;
    pos = live ? (pos + 1) % FRAME : 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1);
      n_cmp++;
      if (obs !== IDLE_VEC) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", obs, IDLE_VEC); end
      n_cmp++;
      if (rd_addr !== 32'h0) begin n_bad++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      n_cmp++;
      if (frame_start !== (i == 2)) begin n_bad++; $display("FAIL first_frame_start cycle %0d: got %b want %b", i + 1, frame_start, i == 2); end
      n_cmp++;
      if (obs !== exp_out.vec) begin n_bad++; $display("FAIL reset_release_vec: got %h want %h", obs, exp_out.vec); end
    end
  endtask

  task automatic test_free_run();
    int nfs = 0, t = 0, t_fs = 0, period = 0, hs_low = 0, vs_low = 0, line_hs = 0;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      tick(1'b0, 1'b1);
      t++;
      n_cmp++;
      if (obs !== exp_out.vec) begin n_bad++; $display("FAIL free_run_vec at (%0d,%0d): got %h want %h", exp_out.h, exp_out.v, obs, exp_out.vec); end
      n_cmp++;
      if (rd_addr !== exp_addr) begin n_bad++; $display("FAIL free_run_rd_addr: got %h want %h", rd_addr, exp_addr); end
      if (frame_start === 1'b1) begin
        nfs++;
        if (nfs == 2) period = t - t_fs;
        t_fs = t;
      end
      if (nfs == 1) begin
        if (hsync === 1'b0) hs_low++;
        if (vsync === 1'b0) vs_low++;
        if (hsync === 1'b0 && t - t_fs < HT) line_hs++;
      end
    end
    n_cmp++;
    if (nfs != 2) begin n_bad++; $display("FAIL frame_start_count: got %0d want 2", nfs); end
    n_cmp++;
    if (period != FRAME) begin n_bad++; $display("FAIL frame_period: got %0d want %0d", period, FRAME); end
    n_cmp++;
    if (line_hs != HSW) begin n_bad++; $display("FAIL hsync_low_per_line: got %0d want %0d", line_hs, HSW); end
    n_cmp++;
    if (hs_low != HSW * VT) begin n_bad++; $display("FAIL hsync_low_per_frame: got %0d want %0d", hs_low, HSW * VT); end
    n_cmp++;
    if (vs_low != VSW * HT) begin n_bad++; $display("FAIL vsync_low_per_frame: got %0d want %0d", vs_low, VSW * HT); end
  endtask

  task automatic test_pixels();
    logic [7:0] hits = 8'h00;
    for (int i = 0; i < FRAME + 10; i++) begin
      tick(1'b0, 1'b1);
      n_cmp++;
      if (obs !== exp_out.vec) begin n_bad++; $display("FAIL pixel_vec at (%0d,%0d): got %h want %h", exp_out.h, exp_out.v, obs, exp_out.vec); end
      if (exp_out.h == X0 && exp_out.v == Y0) begin
        hits[0] = 1'b1; n_cmp++;
        if (red !== 8'h00 || blue !== 8'h00) begin n_bad++; $display("FAIL img_origin: got %h want 00", red); end
      end
      if (exp_out.h == X0 + 8 && exp_out.v == Y0) begin
        hits[1] = 1'b1; n_cmp++;
        if (green !== 8'h08) begin n_bad++; $display("FAIL img_col8: got %h want 08", green); end
      end
      if (exp_out.h == X0 && exp_out.v == Y0 + 1) begin
        hits[2] = 1'b1; n_cmp++;
        if (red !== 8'h20) begin n_bad++; $display("FAIL img_row1: got %h want 20", red); end
      end
      if (s0_h == X0 && s0_v == Y0 + 1) begin
        hits[3] = 1'b1; n_cmp++;
        if (rd_addr !== BASE + 32'd32) begin n_bad++; $display("FAIL row1_rd_addr: got %h want %h", rd_addr, BASE + 32'd32); end
      end
      if (exp_out.h == 5 && exp_out.v == 5) begin
        hits[4] = 1'b1; n_cmp++;
        if ({red, active} !== {8'h00, 1'b1}) begin n_bad++; $display("FAIL surround: got rgb %h active %b want 00/1", red, active); end
      end
      if (exp_out.h == 80 && exp_out.v == 3) begin
        hits[5] = 1'b1; n_cmp++;
        if ({red, active, hsync} !== {8'h00, 1'b0, 1'b0}) begin n_bad++; $display("FAIL blanking: got rgb %h active %b hsync %b want 00/0/0", red, active, hsync); end
      end
      if (exp_out.h == X0 - 1 && exp_out.v == Y0 + 2) begin
        hits[6] = 1'b1; n_cmp++;
        if (red !== BORDER_PIX) begin n_bad++; $display("FAIL border_left: got %h want %h", red, BORDER_PIX); end
      end
      if (exp_out.h == X0 + W && exp_out.v == Y0 + 10) begin
        hits[7] = 1'b1; n_cmp++;
        if (blue !== BORDER_PIX) begin n_bad++; $display("FAIL border_right: got %h want %h", blue, BORDER_PIX); end
      end
    end
    n_cmp++;
    if (hits !== 8'hFF) begin n_bad++; $display("FAIL pixel_points_reached: got %b want 11111111", hits); end
  endtask

  task automatic test_enable_drop();
    int tgt, gap;
    bit found = 1'b0;
    tgt = int'($urandom_range(FRAME - 1));
    gap = int'($urandom_range(15, 2));
    for (int i = 0; i < FRAME + 5 && !found; i++) begin
      tick(1'b0, 1'b1);
      n_cmp++;
      if (obs !== exp_out.vec) begin n_bad++; $display("FAIL pre_drop_vec: got %h want %h", obs, exp_out.vec); end
      if (pos == tgt) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL drop_position_timeout: got none want %0d", tgt); end
    for (int i = 0; i < gap; i++) begin
      tick(1'b0, 1'b0);
      n_cmp++;
      if (obs !== IDLE_VEC) begin n_bad++; $display("FAIL disabled_idle cycle %0d: got %h want %h", i, obs, IDLE_VEC); end
      n_cmp++;
      if (rd_addr !== exp_addr) begin n_bad++; $display("FAIL disabled_rd_addr_hold: got %h want %h", rd_addr, exp_addr); end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      n_cmp++;
      if (frame_start !== (i == 2)) begin n_bad++; $display("FAIL reenable_frame_start cycle %0d: got %b want %b", i + 1, frame_start, i == 2); end
    end
    for (int i = 0; i < 2 * HT; i++) begin
      tick(1'b0, 1'b1);
      n_cmp++;
      if (obs !== exp_out.vec) begin n_bad++; $display("FAIL post_reenable_vec at (%0d,%0d): got %h want %h", exp_out.h, exp_out.v, obs, exp_out.vec); end
    end
  endtask

  task automatic test_random();
    int off = 0;
    bit rst;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    key = 8'($urandom());
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 12000; i++) begin
      if (off == 0 && $urandom_range(1999) == 0) off = int'($urandom_range(20, 1));
      rst = ($urandom_range(4999) == 0);
      tick(rst, off == 0);
      if (off > 0) off--;
      n_cmp++;
      if (obs !== exp_out.vec) begin n_bad++; $display("FAIL random_vec at (%0d,%0d): got %h want %h", exp_out.h, exp_out.v, obs, exp_out.vec); end
      n_cmp++;
      if (rd_addr !== exp_addr) begin n_bad++; $display("FAIL random_rd_addr: got %h want %h", rd_addr, exp_addr); end
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    hist[0] = idle_rec(); hist[1] = idle_rec(); hist[2] = idle_rec();
    exp_out = idle_rec();
    test_reset();
    test_free_run();
    test_pixels();
    test_enable_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
